// File: rtl/sha256_w_stream_reader.sv
// SHA-256 message-schedule reader: loads one 512-bit block and streams W0..W(NUM_ROUNDS-1), one word per clock. W0 is valid the cycle after accept; the output holds while w_ready=0.
// Optional SHA256_DBL_PAD_EN adds in_digest, which loads a 256-bit digest with the fixed double-SHA-256 padding.
module sha256_w_stream_reader #(
  parameter int NUM_ROUNDS = 64
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] block_in,
`ifdef SHA256_DBL_PAD_EN
  input  logic         in_digest,
`endif
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_out,
  output logic [5:0]   w_idx,
  output logic         w_last
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);

  state_t      state_q;
  logic [31:0] win_q [16];
  logic [31:0] load_d [16];
  logic [31:0] w15_d;
  logic [5:0]  idx_q;
  logic        in_ready_q;
  logic        w_valid_q;
  logic        w_last_q;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Next word entering the window: W[t+16] from the window holding W[t..t+15].
  always_comb begin
    w15_d = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
  end

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      load_d[i] = block_in[511 - 32*i -: 32];
    end
`ifdef SHA256_DBL_PAD_EN
    if (in_digest) begin
      for (int i = 8; i < 16; i++) begin
        load_d[i] = 32'h0;
      end
      load_d[8]  = 32'h8000_0000;
      load_d[15] = 32'h0000_0100;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b1;
      w_valid_q  <= 1'b0;
      w_last_q   <= 1'b0;
      idx_q      <= 6'd0;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= 32'h0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < 16; i++) begin
              win_q[i] <= load_d[i];
            end
            idx_q      <= 6'd0;
            w_valid_q  <= 1'b1;
            in_ready_q <= 1'b0;
            w_last_q   <= (LAST_IDX == 6'd0);
            state_q    <= STREAM;
          end
        end
        STREAM: begin
          if (w_ready) begin
            if (w_last_q) begin
              w_valid_q  <= 1'b0;
              w_last_q   <= 1'b0;
              in_ready_q <= 1'b1;
              idx_q      <= 6'd0;
              state_q    <= IDLE;
            end else begin
              for (int i = 0; i < 15; i++) begin
                win_q[i] <= win_q[i+1];
              end
              win_q[15] <= w15_d;
              idx_q     <= idx_q + 6'd1;
              w_last_q  <= ((idx_q + 6'd1) == LAST_IDX);
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
          w_valid_q  <= 1'b0;
          w_last_q   <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign w_valid  = w_valid_q;
  assign w_out    = win_q[0];
  assign w_idx    = idx_q;
  assign w_last   = w_last_q;

endmodule

// File: tb/tb_sha256_w_stream_reader.sv
// Bench for sha256_w_stream_reader: full 64-round instance plus a 17-round instance, checked against a plain-array schedule model.
module tb_sha256_w_stream_reader;

  logic         CLK;
  logic         RST;

  logic         a_in_valid, a_in_ready, a_w_valid, a_w_ready, a_w_last;
  logic [511:0] a_block;
  logic [31:0]  a_w_out;
  logic [5:0]   a_w_idx;
  logic         b_in_valid, b_in_ready, b_w_valid, b_w_ready, b_w_last;
  logic [511:0] b_block;
  logic [31:0]  b_w_out;
  logic [5:0]   b_w_idx;
`ifdef SHA256_DBL_PAD_EN
  logic         a_in_digest, b_in_digest;
`endif

  int           vectors;
  int           miscompares;
  bit           sel;
  logic [31:0]  exp_w [64];
  logic [31:0]  got_w [64];

  logic         o_valid, o_in_ready, o_last;
  logic [31:0]  o_out;
  logic [5:0]   o_idx;

  localparam logic [511:0] ABC = {32'h6162_6380, 448'h0, 32'h0000_0018};

  sha256_w_stream_reader #(.NUM_ROUNDS(64)) dut_a (
    .CLK(CLK), .RST(RST),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .block_in(a_block),
`ifdef SHA256_DBL_PAD_EN
    .in_digest(a_in_digest),
`endif
    .w_valid(a_w_valid), .w_ready(a_w_ready), .w_out(a_w_out),
    .w_idx(a_w_idx), .w_last(a_w_last)
  );

  sha256_w_stream_reader #(.NUM_ROUNDS(17)) dut_b (
    .CLK(CLK), .RST(RST),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .block_in(b_block),
`ifdef SHA256_DBL_PAD_EN
    .in_digest(b_in_digest),
`endif
    .w_valid(b_w_valid), .w_ready(b_w_ready), .w_out(b_w_out),
    .w_idx(b_w_idx), .w_last(b_w_last)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always_comb begin
    o_valid    = sel ? b_w_valid  : a_w_valid;
    o_in_ready = sel ? b_in_ready : a_in_ready;
    o_last     = sel ? b_w_last   : a_w_last;
    o_out      = sel ? b_w_out    : a_w_out;
    o_idx      = sel ? b_w_idx    : a_w_idx;
  end

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook schedule recurrence over the whole 64-entry array.
  task automatic model(input logic [511:0] blk, input bit dig);
    for (int t = 0; t < 16; t++) exp_w[t] = blk[511 - 32*t -: 32];
    if (dig) begin
      for (int t = 8; t < 16; t++) exp_w[t] = 32'h0;
      exp_w[8]  = 32'h8000_0000;
      exp_w[15] = 32'h0000_0100;
    end
    for (int t = 16; t < 64; t++)
      exp_w[t] = (rr(exp_w[t-2], 17) ^ rr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10)) + exp_w[t-7]
               + (rr(exp_w[t-15], 7) ^ rr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3)) + exp_w[t-16];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit v, input logic [511:0] blk, input bit dig);
    if (sel) begin b_in_valid = v; b_block = blk; end
    else     begin a_in_valid = v; a_block = blk; end
`ifdef SHA256_DBL_PAD_EN
    if (sel) b_in_digest = dig; else a_in_digest = dig;
`else
    if (dig) chk("digest_unsupported", 32'd1, 32'd0);
`endif
  endtask

  task automatic set_rdy(input bit r);
    if (sel) b_w_ready = r; else a_w_ready = r;
  endtask

  task automatic load(input logic [511:0] blk, input bit dig, input bit keep);
    chk("load_in_ready", 32'(o_in_ready), 32'd1);
    chk("load_w_valid", 32'(o_valid), 32'd0);
    set_in(1'b1, blk, dig);
    model(blk, dig);
    @(negedge CLK);
    if (!keep) set_in(1'b0, blk, 1'b0);
  endtask

  task automatic stream(input int nr, input bit toggle, input int stop_at);
    int k;
    int cyc;
    bit r;
    k = 0;
    cyc = 0;
    while (k < nr) begin
      if (k == stop_at) return;
      if (cyc > 1000) begin
        chk("stream_timeout", 32'(k), 32'(nr));
        return;
      end
      chk($sformatf("w_valid@%0d", k), 32'(o_valid), 32'd1);
      chk($sformatf("w_out@%0d", k), o_out, exp_w[k]);
      chk($sformatf("w_idx@%0d", k), 32'(o_idx), 32'(k));
      chk($sformatf("w_last@%0d", k), 32'(o_last), 32'(k == nr - 1));
      chk($sformatf("in_ready@%0d", k), 32'(o_in_ready), 32'd0);
      got_w[k] = o_out;
      r = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      set_rdy(r);
      if (r) k++;
      cyc++;
      @(negedge CLK);
    end
    set_rdy(1'b0);
  endtask

  task automatic post(input string tag);
    chk({tag, "_w_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(o_in_ready), 32'd1);
    chk({tag, "_w_last"}, 32'(o_last), 32'd0);
  endtask

  initial begin
    logic [511:0] blk;
    vectors = 0;
    miscompares = 0;
    sel = 1'b0;
    RST = 1'b1;
    a_in_valid = 1'b0; a_w_ready = 1'b0; a_block = '0;
    b_in_valid = 1'b0; b_w_ready = 1'b0; b_block = '0;
`ifdef SHA256_DBL_PAD_EN
    a_in_digest = 1'b0; b_in_digest = 1'b0;
`endif
    repeat (3) @(negedge CLK);

    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      #1;
      chk("rst_in_ready", 32'(o_in_ready), 32'd1);
      chk("rst_w_valid", 32'(o_valid), 32'd0);
      chk("rst_w_out", o_out, 32'd0);
      chk("rst_w_idx", 32'(o_idx), 32'd0);
      chk("rst_w_last", 32'(o_last), 32'd0);
    end
    sel = 1'b0;
    RST = 1'b0;
    @(negedge CLK);

    // T1: "abc" block at full rate, plus spot checks of known schedule words.
    load(ABC, 1'b0, 1'b0);
    stream(64, 1'b0, -1);
    post("t1_end");
    chk("t1_W0", got_w[0], 32'h6162_6380);
    chk("t1_W15", got_w[15], 32'h0000_0018);
    chk("t1_W16", got_w[16], 32'h6162_6380);
    chk("t1_W17", got_w[17], 32'h000F_0000);
    chk("t1_W18", got_w[18], 32'h7DA8_6405);
    chk("t1_W19", got_w[19], 32'h6000_03C6);

    // T2: same block and a random block with random consumer stalls.
    load(ABC, 1'b0, 1'b0);
    stream(64, 1'b1, -1);
    post("t2a_end");
    for (int i = 0; i < 16; i++) blk[511 - 32*i -: 32] = $urandom;
    load(blk, 1'b0, 1'b0);
    stream(64, 1'b1, -1);
    post("t2b_end");

    // T3: in_valid held high; the second block is taken right after w_last.
    load(ABC, 1'b0, 1'b1);
    stream(64, 1'b0, -1);
    chk("t3_reaccept_in_ready", 32'(o_in_ready), 32'd1);
    chk("t3_reaccept_w_valid", 32'(o_valid), 32'd0);
    @(negedge CLK);
    set_in(1'b0, ABC, 1'b0);
    stream(64, 1'b0, -1);
    post("t3_end");

    // T4: reset mid-stream at w_idx=20, then a clean restart.
    load(ABC, 1'b0, 1'b0);
    stream(64, 1'b0, 20);
    chk("t4_idx_before_rst", 32'(o_idx), 32'd20);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    set_rdy(1'b0);
    chk("t4_w_valid", 32'(o_valid), 32'd0);
    chk("t4_in_ready", 32'(o_in_ready), 32'd1);
    chk("t4_w_idx", 32'(o_idx), 32'd0);
    chk("t4_w_out", o_out, 32'd0);
    load(ABC, 1'b0, 1'b0);
    stream(64, 1'b0, -1);
    post("t4_end");

`ifdef SHA256_DBL_PAD_EN
    // T5: digest load ignores the low half of block_in.
    blk = ABC;
    for (int i = 8; i < 16; i++) blk[511 - 32*i -: 32] = $urandom;
    load(blk, 1'b1, 1'b0);
    stream(64, 1'b1, -1);
    post("t5_end");
    load(blk, 1'b0, 1'b0);
    stream(64, 1'b0, -1);
    post("t5n_end");
`endif

    // T6: 17-round instance.
    sel = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) blk[511 - 32*i -: 32] = $urandom;
    load(blk, 1'b0, 1'b0);
    stream(17, 1'b1, -1);
    post("t6_end");
    load(ABC, 1'b0, 1'b0);
    stream(17, 1'b0, -1);
    post("t6b_end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
